// File: rtl/stream_pool_if.sv
// Config, status and pixel-stream bundle of stream_pool_engine.
// out_last is present only when POOL_OUT_LAST_EN is defined.
interface stream_pool_if #(
    parameter int ELEM_WIDTH = 8,
    parameter int CHANNELS   = 4
);
    logic                           cfg_start;
    logic [1:0]                     cfg_pool_mode;
    logic [7:0]                     cfg_pool_size;
    logic [7:0]                     cfg_img_height;
    logic [7:0]                     cfg_img_width;
    logic                           busy;
    logic                           cfg_error;
    logic                           done;
    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS*ELEM_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS*ELEM_WIDTH-1:0] out_data;
`ifdef POOL_OUT_LAST_EN
    logic                           out_last;
`endif

    modport master (
`ifdef POOL_OUT_LAST_EN
        input  out_last,
`endif
        output cfg_start, cfg_pool_mode, cfg_pool_size, cfg_img_height, cfg_img_width,
        output in_valid, in_data, out_ready,
        input  busy, cfg_error, done, in_ready, out_valid, out_data
    );

    modport slave (
`ifdef POOL_OUT_LAST_EN
        output out_last,
`endif
        input  cfg_start, cfg_pool_mode, cfg_pool_size, cfg_img_height, cfg_img_width,
        input  in_valid, in_data, out_ready,
        output busy, cfg_error, done, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_pool_engine.sv
// Streaming max/min/avg pooling over a raster pixel stream with one row of accumulators.
// Optional macro POOL_OUT_LAST_EN adds out_last on the final pooled pixel.
module stream_pool_engine #(
    parameter int ELEM_WIDTH     = 8,
    parameter int CHANNELS       = 4,
    parameter int MAX_IMG_WIDTH  = 32,
    parameter int MAX_IMG_HEIGHT = 32,
    parameter int MAX_POOL_SIZE  = 4
) (
    input  logic         clk,
    input  logic         rst,
    stream_pool_if.slave bus
);
    localparam int ACC_W = ELEM_WIDTH + 2 * $clog2(MAX_POOL_SIZE);
    localparam int DW    = CHANNELS * ELEM_WIDTH;
    localparam int AW    = CHANNELS * ACC_W;
    localparam int OCW   = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
    localparam logic [7:0] MAXK8 = 8'(MAX_POOL_SIZE);
    localparam logic [7:0] MAXH8 = 8'(MAX_IMG_HEIGHT);
    localparam logic [7:0] MAXW8 = 8'(MAX_IMG_WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;
    localparam logic [1:0] M_MAX = 2'b00, M_AVG = 2'b01, M_MIN = 2'b10;

    function automatic logic [AW-1:0] widen(input logic [DW-1:0] px);
        logic [AW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++)
            r[c*ACC_W +: ACC_W] = ACC_W'(px[c*ELEM_WIDTH +: ELEM_WIDTH]);
        return r;
    endfunction

    function automatic logic [AW-1:0] combine(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [1:0] mode);
        logic [AW-1:0]    r;
        logic [ACC_W-1:0] x, y;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            x = a[c*ACC_W +: ACC_W];
            y = b[c*ACC_W +: ACC_W];
            case (mode)
                M_MAX:   r[c*ACC_W +: ACC_W] = (x > y) ? x : y;
                M_MIN:   r[c*ACC_W +: ACC_W] = (x < y) ? x : y;
                default: r[c*ACC_W +: ACC_W] = x + y;
            endcase
        end
        return r;
    endfunction

    // Average divides by k*k, which is a shift because avg only accepts power-of-two k.
    function automatic logic [DW-1:0] finalize(input logic [AW-1:0] v, input logic [1:0] mode,
                                               input logic [3:0] sh);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++)
            r[c*ELEM_WIDTH +: ELEM_WIDTH] = (mode == M_AVG) ? ELEM_WIDTH'(v[c*ACC_W +: ACC_W] >> sh)
                                                            : ELEM_WIDTH'(v[c*ACC_W +: ACC_W]);
        return r;
    endfunction

    function automatic logic [2:0] lg2(input logic [7:0] k);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (k[i]) r = 3'(i);
        return r;
    endfunction

    logic [1:0]     state_q, state_d, mode_q, mode_d;
    logic [7:0]     k_q, k_d, h_q, h_d, w_q, w_d;
    logic [3:0]     shift_q, shift_d;
    logic [7:0]     col_q, col_d, row_q, row_d, kc_q, kc_d, kr_q, kr_d, ws_q, ws_d, rs_q, rs_d;
    logic [OCW-1:0] ocol_q, ocol_d;
    logic [AW-1:0]  hp_q, hp_d;
    logic [AW-1:0]  rowbuf_q [MAX_IMG_WIDTH];
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d, busy_q, busy_d, err_q, err_d, done_q, done_d;
    logic           accept, cfg_bad, col_in, row_in, win_end_col, band_end, last_col, last_row;
    logic           rb_we, emit;
    logic [AW-1:0]  hfin, vfin;

    assign bus.in_ready  = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign cfg_bad = (bus.cfg_pool_size == 8'd0) || (bus.cfg_pool_size > MAXK8) ||
                     (bus.cfg_pool_size > bus.cfg_img_height) ||
                     (bus.cfg_pool_size > bus.cfg_img_width) ||
                     (bus.cfg_img_height > MAXH8) || (bus.cfg_img_width > MAXW8) ||
                     (bus.cfg_pool_mode == 2'b11) ||
                     ((bus.cfg_pool_mode == M_AVG) &&
                      ((bus.cfg_pool_size & (bus.cfg_pool_size - 8'd1)) != 8'd0));

    // Columns/rows past the last whole window are consumed but never pooled.
    assign col_in      = ({2'b0, ws_q} + {2'b0, k_q}) <= {2'b0, w_q};
    assign row_in      = ({2'b0, rs_q} + {2'b0, k_q}) <= {2'b0, h_q};
    assign win_end_col = kc_q == k_q - 8'd1;
    assign band_end    = kr_q == k_q - 8'd1;
    assign last_col    = col_q == w_q - 8'd1;
    assign last_row    = row_q == h_q - 8'd1;
    assign hfin        = (kc_q == 8'd0) ? widen(bus.in_data) : combine(hp_q, widen(bus.in_data), mode_q);
    assign vfin        = (kr_q == 8'd0) ? hfin : combine(rowbuf_q[ocol_q], hfin, mode_q);
    assign rb_we       = accept && col_in && row_in && win_end_col;
    assign emit        = rb_we && band_end;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_error = err_q;
    assign bus.done      = done_q;

`ifdef POOL_OUT_LAST_EN
    logic out_last_q, out_last_d, is_last_win;
    assign is_last_win  = (({2'b0, ws_q} + {1'b0, k_q, 1'b0}) > {2'b0, w_q}) &&
                          (({2'b0, rs_q} + {1'b0, k_q, 1'b0}) > {2'b0, h_q});
    assign bus.out_last = out_last_q;
    always_comb begin
        out_last_d = out_last_q && !bus.out_ready;
        if (emit) out_last_d = is_last_win;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) out_last_q <= 1'b0;
        else     out_last_q <= out_last_d;
`endif

    always_comb begin
        state_d = state_q; mode_d = mode_q; k_d = k_q; h_d = h_q; w_d = w_q; shift_d = shift_q;
        col_d = col_q; row_d = row_q; kc_d = kc_q; kr_d = kr_q; ws_d = ws_q; rs_d = rs_q;
        ocol_d = ocol_q; hp_d = hp_q;
        busy_d = busy_q; err_d = err_q; done_d = 1'b0;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: if (bus.cfg_start) begin
                if (cfg_bad) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0; busy_d = 1'b1; state_d = S_RUN;
                    mode_d = bus.cfg_pool_mode; k_d = bus.cfg_pool_size;
                    h_d = bus.cfg_img_height; w_d = bus.cfg_img_width;
                    shift_d = {lg2(bus.cfg_pool_size), 1'b0};
                    col_d = '0; row_d = '0; kc_d = '0; kr_d = '0; ws_d = '0; rs_d = '0; ocol_d = '0;
                end
            end
            S_RUN: if (accept) begin
                hp_d = hfin;
                if (last_col) begin
                    col_d = '0; kc_d = '0; ws_d = '0; ocol_d = '0;
                    if (last_row) begin
                        row_d = '0; kr_d = '0; rs_d = '0; state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 8'd1;
                        kr_d  = band_end ? 8'd0 : kr_q + 8'd1;
                        rs_d  = band_end ? rs_q + k_q : rs_q;
                    end
                end else begin
                    col_d  = col_q + 8'd1;
                    kc_d   = win_end_col ? 8'd0 : kc_q + 8'd1;
                    ws_d   = win_end_col ? ws_q + k_q : ws_q;
                    ocol_d = win_end_col ? ocol_q + 1'b1 : ocol_q;
                end
            end
            S_DRAIN: if (!out_valid_q || bus.out_ready) begin
                done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = finalize(vfin, mode_q, shift_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE; mode_q <= '0; k_q <= '0; h_q <= '0; w_q <= '0; shift_q <= '0;
            col_q <= '0; row_q <= '0; kc_q <= '0; kr_q <= '0; ws_q <= '0; rs_q <= '0;
            ocol_q <= '0; hp_q <= '0; out_data_q <= '0;
            out_valid_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
            for (int i = 0; i < MAX_IMG_WIDTH; i++) rowbuf_q[i] <= '0;
        end else begin
            state_q <= state_d; mode_q <= mode_d; k_q <= k_d; h_q <= h_d; w_q <= w_d;
            shift_q <= shift_d; col_q <= col_d; row_q <= row_d; kc_q <= kc_d; kr_q <= kr_d;
            ws_q <= ws_d; rs_q <= rs_d; ocol_q <= ocol_d; hp_q <= hp_d; out_data_q <= out_data_d;
            out_valid_q <= out_valid_d; busy_q <= busy_d; err_q <= err_d; done_q <= done_d;
            // First row of a band overwrites the entry; vfin already folds later rows in.
            if (rb_we) rowbuf_q[ocol_q] <= vfin;
        end
    end
endmodule

// File: tb/tb_stream_pool_engine.sv
// Directed scoreboard bench for stream_pool_engine: reference pooling model feeds a queue,
// a negedge monitor pops and compares each accepted output beat.
module tb_stream_pool_engine;
    localparam int EW = 8;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_pool_if #(.ELEM_WIDTH(EW), .CHANNELS(CH)) bus ();

    stream_pool_engine #(
        .ELEM_WIDTH(EW), .CHANNELS(CH), .MAX_IMG_WIDTH(32),
        .MAX_IMG_HEIGHT(32), .MAX_POOL_SIZE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [CH*EW-1:0] exp_q[$];
    int frame_px[1024][CH];
    int done_cnt = 0;
    int out_seen = 0;
    int exp_pushed = 0;
    logic prev_stall = 1'b0;
    logic [CH*EW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: stability under stall, scoreboard pop on handshake, done bookkeeping.
    always @(negedge clk) begin
        logic [CH*EW-1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_seen++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e);
                end else begin
                    check("out_unexpected", out_seen, exp_pushed);
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_after_outputs", exp_q.size(), 0);
                check("busy_falls_with_done", bus.busy, 0);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic fill(input int w, input int h, input int pat);
        for (int i = 0; i < w * h; i++) begin
            if (pat == 0) begin
                frame_px[i][0] = i & 255;
                frame_px[i][1] = (15 - i) & 255;
            end else begin
                frame_px[i][0] = int'($urandom_range(0, 255));
                frame_px[i][1] = int'($urandom_range(0, 255));
            end
        end
    endtask

    // Reference: walk every whole window directly; avg divides by k*k.
    task automatic push_expected(input int w, input int h, input int k, input int mode);
        logic [CH*EW-1:0] v;
        int acc, p;
        for (int orow = 0; orow < h / k; orow++) begin
            for (int ocol = 0; ocol < w / k; ocol++) begin
                v = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    acc = (mode == 2) ? 256 : (mode == 0) ? -1 : 0;
                    for (int dy = 0; dy < k; dy++) begin
                        for (int dx = 0; dx < k; dx++) begin
                            p = frame_px[(orow * k + dy) * w + ocol * k + dx][ch];
                            if (mode == 0) acc = (p > acc) ? p : acc;
                            else if (mode == 2) acc = (p < acc) ? p : acc;
                            else acc = acc + p;
                        end
                    end
                    if (mode == 1) acc = acc / (k * k);
                    v[ch*EW +: EW] = EW'(acc);
                end
                exp_q.push_back(v);
                exp_pushed++;
            end
        end
    endtask

    task automatic start(input int mode, input int k, input int h, input int w);
        @(posedge clk); #1;
        bus.cfg_pool_mode  = 2'(mode);
        bus.cfg_pool_size  = 8'(k);
        bus.cfg_img_height = 8'(h);
        bus.cfg_img_width  = 8'(w);
        bus.cfg_start      = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start      = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = {8'(frame_px[i][1]), 8'(frame_px[i][0])};
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                i++;
                guard = 0;
            end else begin
                guard++;
            end
            @(posedge clk); #1;
            if (guard > 200) begin
                check("feed_timeout", i, n);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int mode, input int k, input int h,
                             input int w, input int pat, input bit gaps);
        int cyc = 0;
        fill(w, h, pat);
        done_cnt = 0;
        push_expected(w, h, k, mode);
        start(mode, k, h, w);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_err_clear"}, bus.cfg_error, 0);
        feed(w * h, gaps);
        while (!bus.done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, bus.done, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle_busy"}, bus.busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cfg_start = 1'b0; bus.cfg_pool_mode = '0; bus.cfg_pool_size = '0;
        bus.cfg_img_height = '0; bus.cfg_img_width = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        #2 rst = 1'b1;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cfg_error", bus.cfg_error, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_frame("max4x4", 0, 2, 4, 4, 0, 1'b0);
        run_frame("avg4x4", 1, 2, 4, 4, 0, 1'b0);
        run_frame("min4x4", 2, 2, 4, 4, 0, 1'b0);
        run_frame("max5x5", 0, 2, 5, 5, 0, 1'b1);
        run_frame("avg8x8k4", 1, 4, 8, 8, 1, 1'b1);
        run_frame("min7x6k3", 2, 3, 6, 7, 1, 1'b0);
        run_frame("pass_k1", 0, 1, 3, 3, 1, 1'b0);

        // Downstream stall after the first output.
        fork
            run_frame("bp8x8", 0, 2, 8, 8, 1, 1'b1);
            begin
                int c = 0;
                while (!bus.out_valid && c < 500) begin
                    @(posedge clk); #1;
                    c++;
                end
                check("bp_saw_output", bus.out_valid, 1);
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready", bus.in_ready, 0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join

        start(1, 3, 4, 4);
        check("err_avg_k3", bus.cfg_error, 1);
        check("err_avg_k3_busy", bus.busy, 0);
        start(3, 2, 4, 4);
        check("err_mode11", bus.cfg_error, 1);
        check("err_mode11_busy", bus.busy, 0);
        start(0, 5, 8, 8);
        check("err_k5", bus.cfg_error, 1);
        start(0, 4, 3, 8);
        check("err_k_gt_h", bus.cfg_error, 1);
        start(0, 2, 33, 8);
        check("err_h_gt_max", bus.cfg_error, 1);
        run_frame("after_err", 0, 2, 4, 4, 1, 1'b0);

        // Reset in the middle of a frame, then a clean frame.
        fill(8, 8, 1);
        push_expected(8, 8, 2, 0);
        start(0, 2, 8, 8);
        feed(20, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_done", bus.done, 0);
        exp_pushed = exp_pushed - exp_q.size();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame("post_rst", 0, 2, 8, 8, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
